// File: rtl/fifo_reader.sv
// Consumer-side read controller for the small FIFO: issues pops, absorbs the
// one-cycle read latency in a skid buffer and hands words downstream on valid/ready.
module fifo_reader #(
    parameter int DATA_W     = 12,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              pop,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  words_read,
    output logic              idle
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mem_q [SKID_DEPTH];
    logic [DATA_W-1:0]   mem_d [SKID_DEPTH];

    logic                xfer;
    logic [OCC_W:0]      pending;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(SKID_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign valid_out  = (occ_q != '0);
    assign data_out   = data_q;
    assign words_read = words_q;
    assign idle       = (state_q == S_IDLE);
    assign xfer       = valid_out & rd_ready;

    // Occupancy after this edge: captured in-flight word in, transferred word out.
    assign pending = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, xfer};
    assign pop     = (state_q == S_ACTIVE) & ~fifo_empty & (pending < (OCC_W + 1)'(SKID_DEPTH));

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = pop;
        occ_d      = pending[OCC_W-1:0];
        words_d    = words_q + {{(CNT_W - 1){1'b0}}, xfer};
        if (inflight_q) begin
            mem_d[wr_ptr_q] = fifo_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (xfer) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // data_out is a register tracking the next head so it holds when the buffer drains.
        data_d = (occ_d != '0) ? mem_d[rd_ptr_d] : data_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                // A pop issued this very cycle also counts as outstanding work.
                if (!enable) begin
                    state_d = ((occ_q != '0) || inflight_q || pop) ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (enable) begin
                    state_d = S_ACTIVE;
                end else if (pending == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            words_q    <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            words_q    <= words_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO read port model.
module tb_fifo_reader;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              rd_ready = 1'b0;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [CNT_W-1:0]  words_read;
    logic              idle;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] fmem [0:1023];
    int fhead = 0;
    int ftail = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (fhead == ftail);

    // FIFO read port: data_out registered one cycle after the pop.
    always @(posedge clk) begin
        if (pop) begin
            fifo_data <= fmem[fhead];
            fhead     <= fhead + 1;
        end
    end

    fifo_reader #(.DATA_W(DATA_W), .SKID_DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .pop       (pop),
        .rd_ready  (rd_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .words_read(words_read),
        .idle      (idle)
    );

    task automatic load(input logic [DATA_W-1:0] w);
        fmem[ftail] = w;
        ftail = ftail + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        load(12'hABC);
        enable = 1'b1;
        rd_ready = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (pop !== 1'b0 || valid_out !== 1'b0 || idle !== 1'b1 || data_out !== 12'h000 || words_read !== 8'd0) begin
                errors++;
                $display("FAIL reset_cyc%0d: pop=%b valid=%b idle=%b data=%h words=%0d, want 0 0 1 000 0",
                         i, pop, valid_out, idle, data_out, words_read);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (pop !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: pop=%b idle=%b, want pop=0 idle=1", pop, idle);
        end
    endtask

    task automatic test_single();
        @(negedge clk); #1;
        checks++;
        if (pop !== 1'b1 || idle !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_t0: pop=%b idle=%b valid=%b, want 1 0 0", pop, idle, valid_out);
        end
        @(negedge clk); #1;
        checks++;
        if (pop !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: pop=%b valid=%b, want 0 0", pop, valid_out);
        end
        @(negedge clk); #1;
        checks++;
        if (valid_out !== 1'b1 || data_out !== 12'hABC || words_read !== 8'd0) begin
            errors++;
            $display("FAIL single_t2: valid=%b data=%h words=%0d, want 1 abc 0", valid_out, data_out, words_read);
        end
        @(negedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 12'hABC || words_read !== 8'd1 || pop !== 1'b0) begin
            errors++;
            $display("FAIL single_t3: valid=%b data=%h words=%0d pop=%b, want 0 abc 1 0",
                     valid_out, data_out, words_read, pop);
        end
        enable = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: idle=%b, want 1", idle);
        end
    endtask

    task automatic test_stream();
        int npop, pfirst, plast, nrx, rfirst, rlast, bad;
        npop = 0; pfirst = -1; plast = -1; nrx = 0; rfirst = -1; rlast = -1; bad = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) load(DATA_W'(i));
        enable = 1'b1;
        rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            if (pop) begin
                npop++;
                if (pfirst < 0) pfirst = k;
                plast = k;
            end
            if (valid_out && rd_ready) begin
                nrx++;
                if (rfirst < 0) rfirst = k;
                rlast = k;
                if (data_out !== DATA_W'(nrx)) bad++;
            end
        end
        checks++;
        if (npop != 8 || plast - pfirst != 7) begin
            errors++;
            $display("FAIL stream_pops: count=%0d span=%0d, want 8 7", npop, plast - pfirst);
        end
        checks++;
        if (nrx != 8 || rlast - rfirst != 7 || bad != 0) begin
            errors++;
            $display("FAIL stream_data: words=%0d span=%0d misordered=%0d, want 8 7 0", nrx, rlast - rfirst, bad);
        end
        checks++;
        if (words_read !== 8'd8 || pop !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: words_read=%0d pop=%b, want 8 0", words_read, pop);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int npop, nrx, bad;
        npop = 0; nrx = 0; bad = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) load(DATA_W'(i));
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rd_ready = !(k >= 3 && k <= 7);
            #1;
            if (k == 4 || k == 7) begin
                checks++;
                if (pop !== 1'b0 || valid_out !== 1'b1 || data_out !== 12'h002) begin
                    errors++;
                    $display("FAIL bp_hold_k%0d: pop=%b valid=%b data=%h, want 0 1 002", k, pop, valid_out, data_out);
                end
            end
            if (k == 8) begin
                checks++;
                if (pop !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_resume: pop=%b, want 1", pop);
                end
            end
            if (pop) npop++;
            if (valid_out && rd_ready) begin
                nrx++;
                if (data_out !== DATA_W'(nrx)) bad++;
            end
        end
        checks++;
        if (npop != 8 || nrx != 8 || bad != 0 || words_read !== 8'd8) begin
            errors++;
            $display("FAIL bp_stream: pops=%0d words=%0d misordered=%0d words_read=%0d, want 8 8 0 8",
                     npop, nrx, bad, words_read);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] last_rx;
        last_rx = '0;
        do_reset();
        load(12'h111);
        load(12'h222);
        load(12'h333);
        enable = 1'b1;
        rd_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++;
            if (pop !== 1'b1) begin
                errors++;
                $display("FAIL flush_pop_k%0d: pop=%b, want 1", k, pop);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (pop !== 1'b0 || valid_out !== 1'b1 || data_out !== 12'h111) begin
            errors++;
            $display("FAIL flush_full: pop=%b valid=%b data=%h, want 0 1 111", pop, valid_out, data_out);
        end
        enable = 1'b0;
        @(negedge clk);
        rd_ready = 1'b1;
        #1;
        checks++;
        if (idle !== 1'b0 || pop !== 1'b0 || valid_out !== 1'b1 || data_out !== 12'h111) begin
            errors++;
            $display("FAIL flush_w0: idle=%b pop=%b valid=%b data=%h, want 0 0 1 111", idle, pop, valid_out, data_out);
        end
        @(negedge clk); #1;
        checks++;
        if (idle !== 1'b0 || pop !== 1'b0 || valid_out !== 1'b1 || data_out !== 12'h222) begin
            errors++;
            $display("FAIL flush_w1: idle=%b pop=%b valid=%b data=%h, want 0 0 1 222", idle, pop, valid_out, data_out);
        end
        @(negedge clk); #1;
        checks++;
        if (idle !== 1'b1 || valid_out !== 1'b0 || pop !== 1'b0 || words_read !== 8'd2 || fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: idle=%b valid=%b pop=%b words=%0d empty=%b, want 1 0 0 2 0",
                     idle, valid_out, pop, words_read, fifo_empty);
        end
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (valid_out && rd_ready) last_rx = data_out;
        end
        checks++;
        if (words_read !== 8'd3 || last_rx !== 12'h333) begin
            errors++;
            $display("FAIL flush_reenable: words=%0d last=%h, want 3 333", words_read, last_rx);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int n, bad;
        n = 0; bad = 0;
        do_reset();
        for (int i = 0; i < 257; i++) load(DATA_W'(i * 3));
        enable = 1'b1;
        rd_ready = 1'b1;
        for (int k = 0; k < 400 && n < 257; k++) begin
            @(negedge clk); #1;
            if (valid_out && rd_ready) begin
                if (data_out !== DATA_W'(n * 3)) bad++;
                n++;
            end
        end
        checks++;
        if (n != 257 || bad != 0) begin
            errors++;
            $display("FAIL wrap_stream: words=%0d misordered=%0d, want 257 0", n, bad);
        end
        @(negedge clk); #1;
        checks++;
        if (words_read !== 8'd1) begin
            errors++;
            $display("FAIL wrap_count: words_read=%0d, want 1", words_read);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        seen = 0;
        load(12'hA01);
        load(12'hA02);
        load(12'hA03);
        load(12'hA04);
        enable = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (valid_out !== 1'b1 || data_out !== 12'hA01 || pop !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b data=%h pop=%b, want 1 a01 0", valid_out, data_out, pop);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 12'h000 || pop !== 1'b0 || idle !== 1'b1 || words_read !== 8'd0) begin
            errors++;
            $display("FAIL midrst_now: valid=%b data=%h pop=%b idle=%b words=%0d, want 0 000 0 1 0",
                     valid_out, data_out, pop, idle, words_read);
        end
        reset = 1'b0;
        enable = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (valid_out) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_after: valid cycles=%0d, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
